mem_port_arbiter: RTL

- Shares the single main-memory block port between the instruction cache (refill reads only) and the data cache (refill reads and write-backs).
- Sits between both cache controllers and the memory model, and sequences every memory transaction.
- Uses the same busywait handshake on both sides.
- Arbitration is round-robin when both requesters wait, so neither cache starves.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory block port between the icache (refill reads) and the
// dcache (refill reads and write-backs), round-robin on contention, one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic               timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic               owner;       // 0 = icache, 1 = dcache
    logic               op_write;
    logic               last_grant;  // 0 = icache, 1 = dcache
    logic [CNT_W-1:0]   wait_cnt;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic grant_wr;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    // On a tie the requester that did not get the last grant wins.
    assign grant_d  = d_req & (~i_req | ~last_grant);
    assign grant_wr = grant_d & d_write;

    assign i_busywait = i_read & ~((state == DONE) & ~owner);
    assign d_busywait = d_req  & ~((state == DONE) &  owner);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            op_write      <= 1'b0;
            last_grant    <= 1'b1;
            wait_cnt      <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        owner         <= grant_d;
                        op_write      <= grant_wr;
                        mem_read      <= ~grant_wr;
                        mem_write     <= grant_wr;
                        mem_address   <= grant_d ? d_address : i_address;
                        mem_writedata <= grant_wr ? d_writedata : '0;
                        state         <= ISSUE;
                    end
                end
                // Memory raises busywait one cycle late, so it is not looked at here.
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (wait_cnt != CNT_W'(TIMEOUT))
                        wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(TIMEOUT - 1))
                        timeout_err <= 1'b1;
                    if (!mem_busywait) begin
                        if (!op_write) begin
                            if (owner) d_readdata <= mem_readdata;
                            else       i_readdata <= mem_readdata;
                        end
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
